serial_add_ctrl: RTL and testbench

Bit-serial add/subtract engine that time-multiplexes a single `full_adder` instance over a WIDTH-bit operand pair, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake. Processing elements use it wherever a full-width ripple adder costs too much area and a latency of WIDTH+1 cycles is acceptable.

---
 rtl/serial_add_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract engine sharing one full adder, LSB first

// Single-bit full adder, the only arithmetic element of the engine
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// Start/busy/done controller that walks one full adder across WIDTH bits
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;

  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  full_adder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at bit 0
  assign w_res_next = WIDTH'({w_fa_s, r_res} >> 1);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  // Controller FSM with datapath shift registers and registered result outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            // Subtract is a + ~b + 1: invert B here and seed the carry with 1
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub;
            r_cnt   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_res   <= w_res_next;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_fa_c;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // r_carry still holds the carry into the MSB on this final bit
            r_sum      <= w_res_next;
            r_cout     <= w_fa_c;
            r_overflow <= r_carry ^ w_fa_c;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_sum      = r_sum;
  assign o_cout     = r_cout;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl at WIDTH=8

module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  exp_t q[$];
  int   n_pass;
  int   n_checks;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_sub      (sub),
    .i_a        (a),
    .i_b        (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_sum      (sum),
    .o_cout     (cout),
    .o_overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width arithmetic, carry into MSB from the low W-1 bits
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic [W-1:0] low;
    exp_t         e;
    bb     = ms ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bb} + (W+1)'(ms);
    low    = {1'b0, ma[W-2:0]} + {1'b0, bb[W-2:0]} + W'(ms);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ov   = low[W-1] ^ full[W];
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input bit push);
    a     = ta;
    b     = tb;
    sub   = ts;
    start = 1'b1;
    if (push) q.push_back(model(ta, tb, ts));
    tick();
    start = 1'b0;
  endtask

  // Waits for done with a cycle budget; the callers judge the counts
  task automatic wait_done(output int cyc, output int nbusy, output bit both);
    cyc   = 0;
    nbusy = 0;
    both  = 1'b0;
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      tick();
      cyc++;
    end
    if (busy && done) both = 1'b1;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (sum !== '0) $display("FAIL reset_sum got %h want 00", sum); else n_pass++;
    n_checks++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_add;
    int cyc, nb; bit both; exp_t e;
    start_op(8'h5A, 8'h33, 1'b0, 1'b1);
    wait_done(cyc, nb, both);
    n_checks++; if (cyc !== W) $display("FAIL add_latency got %0d want %0d", cyc, W); else n_pass++;
    n_checks++; if (nb !== W) $display("FAIL add_busy_cycles got %0d want %0d", nb, W); else n_pass++;
    n_checks++; if (both !== 1'b0) $display("FAIL add_busy_done_overlap got 1 want 0"); else n_pass++;
    n_checks++;
    if (q.size() == 0) $display("FAIL add_scoreboard_empty got none want entry");
    else begin
      e = q.pop_front();
      if ({sum, cout, overflow} !== e) $display("FAIL add_result got %h/%b/%b want %h/%b/%b", sum, cout, overflow, e.sum, e.cout, e.ov);
      else n_pass++;
    end
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL add_done_pulse got %b want 0", done); else n_pass++;
  endtask

  task automatic test_arith(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    int cyc, nb; bit both; exp_t e;
    start_op(ta, tb, ts, 1'b1);
    wait_done(cyc, nb, both);
    n_checks++;
    if (q.size() == 0) $display("FAIL arith_scoreboard_empty got none want entry");
    else begin
      e = q.pop_front();
      if (cyc !== W || {sum, cout, overflow} !== e)
        $display("FAIL arith_%h_%h_%b got %h/%b/%b lat %0d want %h/%b/%b lat %0d", ta, tb, ts, sum, cout, overflow, cyc, e.sum, e.cout, e.ov, W);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_busy_protect;
    int cyc, nb, extra; bit both; exp_t e;
    start_op(8'h01, 8'h01, 1'b0, 1'b1);
    repeat (2) tick();
    start_op(8'hAA, 8'h55, 1'b0, 1'b0);
    wait_done(cyc, nb, both);
    n_checks++;
    if (q.size() == 0) $display("FAIL busy_scoreboard_empty got none want entry");
    else begin
      e = q.pop_front();
      if (!done || {sum, cout, overflow} !== e) $display("FAIL busy_result got %h/%b/%b done %b want %h/%b/%b", sum, cout, overflow, done, e.sum, e.cout, e.ov);
      else n_pass++;
    end
    extra = 0;
    repeat (20) begin
      tick();
      if (done) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL busy_second_done got %0d want 0", extra); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL busy_idle_after got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int cyc, nb, ndone; bit both; exp_t e;
    start_op(8'h5A, 8'h33, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, sum, cout, overflow} !== '0)
      $display("FAIL rstmid_outputs got busy %b done %b sum %h cout %b ov %b want all 0", busy, done, sum, cout, overflow);
    else n_pass++;
    tick();
    rst   = 1'b0;
    ndone = 0;
    repeat (15) begin
      tick();
      if (done || busy) ndone++;
    end
    n_checks++; if (ndone !== 0) $display("FAIL rstmid_no_done got %0d want 0", ndone); else n_pass++;
    start_op(8'h03, 8'h04, 1'b0, 1'b1);
    wait_done(cyc, nb, both);
    n_checks++;
    if (q.size() == 0) $display("FAIL rstmid_scoreboard_empty got none want entry");
    else begin
      e = q.pop_front();
      if (cyc !== W || {sum, cout, overflow} !== e) $display("FAIL rstmid_new_op got %h/%b/%b want %h/%b/%b", sum, cout, overflow, e.sum, e.cout, e.ov);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int cyc1, cyc2, nb; bit both; exp_t e;
    a     = 8'h11;
    b     = 8'h22;
    sub   = 1'b0;
    start = 1'b1;
    q.push_back(model(8'h11, 8'h22, 1'b0));
    tick();
    wait_done(cyc1, nb, both);
    n_checks++;
    if (q.size() == 0) $display("FAIL b2b_first_scoreboard_empty got none want entry");
    else begin
      e = q.pop_front();
      if (cyc1 !== W || {sum, cout, overflow} !== e) $display("FAIL b2b_first got %h/%b/%b lat %0d want %h/%b/%b lat %0d", sum, cout, overflow, cyc1, e.sum, e.cout, e.ov, W);
      else n_pass++;
    end
    a = 8'h0F;
    b = 8'h01;
    q.push_back(model(8'h0F, 8'h01, 1'b0));
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_reaccept got busy %b done %b want 1 0", busy, done); else n_pass++;
    repeat (4) tick();
    n_checks++; if (sum !== 8'h33) $display("FAIL b2b_hold got %h want 33", sum); else n_pass++;
    wait_done(cyc2, nb, both);
    n_checks++; if (cyc2 + 5 !== W + 1) $display("FAIL b2b_spacing got %0d want %0d", cyc2 + 5, W + 1); else n_pass++;
    n_checks++;
    if (q.size() == 0) $display("FAIL b2b_second_scoreboard_empty got none want entry");
    else begin
      e = q.pop_front();
      if ({sum, cout, overflow} !== e) $display("FAIL b2b_second got %h/%b/%b want %h/%b/%b", sum, cout, overflow, e.sum, e.cout, e.ov);
      else n_pass++;
    end
    tick();
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    test_reset();
    test_add();
    test_arith(8'hFF, 8'h01, 1'b0);
    test_arith(8'h10, 8'h20, 1'b1);
    test_arith(8'h80, 8'h01, 1'b1);
    test_arith(8'h00, 8'h00, 1'b1);
    test_arith(8'h80, 8'h80, 1'b0);
    test_arith(8'h7F, 8'h80, 1'b1);
    test_busy_protect();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
